// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Latency-delayed 32-bit word load/store responder with error status
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int c_IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic [c_IDX_W-1:0] w_idx;
  logic               w_err;
  logic               w_we;

  // Depth is a power of two, so any set bit above the index field is out of range.
  assign w_idx = addr_q[c_IDX_W+1:2];
  assign w_err = (addr_q[1:0] != 2'b00)
              || (addr_q[31:c_IDX_W+2] != '0)
              || (rd_q == wr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    w_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          wdata_d = data_i;
          rd_d    = MemRead_i;
          wr_d    = MemWrite_i;
          cnt_d   = 4'(LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Busy rises one edge after acceptance and falls as the response retires.
        busy_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          err_d   = w_err;
          if (!w_err) begin
            if (rd_q) begin
              rdata_d = mem_q[w_idx];
            end else begin
              w_we = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (w_we) begin
      mem_q[w_idx] <= wdata_q;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = rdata_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder at LATENCY 2 and 0
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn, req, rd, wr, ready, err, busy;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] dout  [2];

  int          lat [2] = '{2, 0};
  logic [31:0] mm [2][DEPTH];
  logic [31:0] exp_d [2];
  logic        exp_e [2];
  int          checks   = 0;
  int          failures = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_l2 (
    .clk_i(clk), .rst_i(rstn[0]), .req_i(req[0]), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
    .addr_i(addr[0]), .data_i(wdata[0]), .ready_o(ready[0]), .data_o(dout[0]),
    .err_o(err[0]), .busy_o(busy[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_l0 (
    .clk_i(clk), .rst_i(rstn[1]), .req_i(req[1]), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
    .addr_i(addr[1]), .data_i(wdata[1]), .ready_o(ready[1]), .data_o(dout[1]),
    .err_o(err[1]), .busy_o(busy[1])
  );

  // Reference model: word array plus the last completion status and load data.
  function automatic bit is_err(bit r, bit w, logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH) || (r == w);
  endfunction

  task automatic model_apply(input int s, input bit r, input bit w,
                             input logic [31:0] a, input logic [31:0] d);
    if (is_err(r, w, a)) begin
      exp_e[s] = 1'b1;
    end else begin
      exp_e[s] = 1'b0;
      if (w) mm[s][a >> 2] = d;
      else   exp_d[s] = mm[s][a >> 2];
    end
  endtask

  task automatic model_reset(input int s);
    for (int i = 0; i < DEPTH; i++) mm[s][i] = 32'd0;
    exp_d[s] = 32'd0;
    exp_e[s] = 1'b0;
  endtask

  // Issues one request at the current negedge and checks its whole timeline.
  task automatic xact(input int s, input bit r, input bit w,
                      input logic [31:0] a, input logic [31:0] d, input string nm);
    int l;
    bit exp_rdy, exp_bsy;
    l = lat[s];
    req[s] = 1'b1; rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d;
    @(negedge clk);
    req[s] = 1'b0; rd[s] = 1'($urandom); wr[s] = 1'($urandom);
    addr[s] = $urandom; wdata[s] = $urandom;
    model_apply(s, r, w, a, d);
    for (int k = 0; k <= l + 2; k++) begin
      if (k > 0) @(negedge clk);
      exp_rdy = (k == l + 1);
      exp_bsy = (k >= 1) && (k <= l + 1);
      checks++;
      if (ready[s] !== exp_rdy) begin
        failures++;
        $display("FAIL %s ready k=%0d: got %b expected %b", nm, k, ready[s], exp_rdy);
      end
      checks++;
      if (busy[s] !== exp_bsy) begin
        failures++;
        $display("FAIL %s busy k=%0d: got %b expected %b", nm, k, busy[s], exp_bsy);
      end
      if (k >= l + 1) begin
        checks++;
        if (err[s] !== exp_e[s]) begin
          failures++;
          $display("FAIL %s err k=%0d: got %b expected %b", nm, k, err[s], exp_e[s]);
        end
        checks++;
        if (dout[s] !== exp_d[s]) begin
          failures++;
          $display("FAIL %s data k=%0d: got %h expected %h", nm, k, dout[s], exp_d[s]);
        end
      end
    end
  endtask

  task automatic check_zero(input int s, input string nm);
    checks++;
    if (ready[s] !== 1'b0 || busy[s] !== 1'b0 || err[s] !== 1'b0 || dout[s] !== 32'd0) begin
      failures++;
      $display("FAIL %s: got ready=%b busy=%b err=%b data=%h expected all zero",
               nm, ready[s], busy[s], err[s], dout[s]);
    end
  endtask

  task automatic test_reset();
    req = '0; rd = '0; wr = '0;
    addr = '{32'd0, 32'd0}; wdata = '{32'd0, 32'd0};
    rstn = 2'b11;
    #1 rstn = 2'b00;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    check_zero(0, "reset_l2");
    check_zero(1, "reset_l0");
    rstn = 2'b11;
    @(negedge clk);
    xact(0, 1'b1, 1'b0, 32'h0, 32'h0, "rst_load0_l2");
    xact(1, 1'b1, 1'b0, 32'h0, 32'h0, "rst_load0_l0");
  endtask

  task automatic test_store_load();
    xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "store_10");
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, "load_10");
    checks++;
    if (dout[0] !== 32'hDEADBEEF || err[0] !== 1'b0) begin
      failures++;
      $display("FAIL load_10_const: got data=%h err=%b expected deadbeef/0", dout[0], err[0]);
    end
  endtask

  task automatic test_errors();
    xact(0, 1'b0, 1'b1, 32'h12,  32'h11111111, "err_misaligned");
    xact(0, 1'b0, 1'b1, 32'h200, 32'h22222222, "err_range");
    xact(0, 1'b1, 1'b1, 32'h10,  32'h33333333, "err_both");
    xact(0, 1'b0, 1'b0, 32'h10,  32'h44444444, "err_neither");
    checks++;
    if (err[0] !== 1'b1 || dout[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL err_hold: got err=%b data=%h expected 1/deadbeef", err[0], dout[0]);
    end
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, "err_recheck_10");
    xact(0, 1'b1, 1'b0, 32'h0,  32'h0, "err_recheck_0");
  endtask

  task automatic test_busy_hold();
    logic [31:0] junk [4];
    logic [31:0] d1, d2;
    bit          exp_rdy;
    d1 = $urandom;
    d2 = $urandom;
    req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h60; wdata[0] = d1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      exp_rdy = (k == 3) || (k == 8);
      checks++;
      if (ready[0] !== exp_rdy) begin
        failures++;
        $display("FAIL busy_hold ready k=%0d: got %b expected %b", k, ready[0], exp_rdy);
      end
      if (k <= 3) begin
        junk[k] = 32'($urandom_range(16, 63)) << 2;
        addr[0] = junk[k]; wdata[0] = $urandom;
      end else if (k == 4) begin
        addr[0] = 32'h64; wdata[0] = d2;
      end else begin
        req[0] = 1'b0;
      end
    end
    model_apply(0, 1'b0, 1'b1, 32'h60, d1);
    model_apply(0, 1'b0, 1'b1, 32'h64, d2);
    xact(0, 1'b1, 1'b0, 32'h60, 32'h0, "hold_first");
    xact(0, 1'b1, 1'b0, 32'h64, 32'h0, "hold_second");
    for (int j = 0; j < 4; j++) xact(0, 1'b1, 1'b0, junk[j], 32'h0, "hold_junk");
  endtask

  task automatic test_reset_midop();
    int pulses;
    xact(0, 1'b0, 1'b1, 32'h40, 32'hA5A50F0F, "mid_prep_store");
    xact(0, 1'b1, 1'b0, 32'h40, 32'h0, "mid_prep_load");
    xact(0, 1'b1, 1'b1, 32'h40, 32'h0, "mid_prep_err");
    req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    @(negedge clk);
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy: got %b expected 1", busy[0]);
    end
    #1 rstn[0] = 1'b0;
    #1 check_zero(0, "mid_reset_immediate");
    model_reset(0);
    @(negedge clk);
    rstn[0] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL mid_no_ready: got %0d pulses expected 0", pulses);
    end
    xact(0, 1'b1, 1'b0, 32'h20, 32'h0, "mid_load_20");
    checks++;
    if (dout[0] !== 32'h0) begin
      failures++;
      $display("FAIL mid_load_20_const: got %h expected 00000000", dout[0]);
    end
    xact(0, 1'b1, 1'b0, 32'h40, 32'h0, "mid_load_40");
  endtask

  task automatic test_lat0_sweep();
    for (int i = 0; i < 16; i++)
      xact(1, 1'b0, 1'b1, 32'(i * 4), 32'(i * 12), "sweep_store");
    for (int i = 0; i < 16; i++) begin
      xact(1, 1'b1, 1'b0, 32'(i * 4), 32'h0, "sweep_load");
      checks++;
      if (dout[1] !== 32'(i * 12)) begin
        failures++;
        $display("FAIL sweep_const word %0d: got %h expected %h", i, dout[1], 32'(i * 12));
      end
    end
  endtask

  task automatic test_random();
    int          s, kind;
    bit          r, w;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      s    = n % 2;
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 15)) << 2;
      r    = 1'($urandom);
      w    = !r;
      if (kind == 0) a = a | 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'($urandom_range(128, 4000)) << 2;
      else if (kind == 2) w = r;
      xact(s, r, w, a, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_busy_hold();
    test_reset_midop();
    test_lat0_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the CPU data-memory port: accepts one load or store request from the datapath, holds it for a configurable access latency, then performs a word access on internal storage and returns a one-cycle completion pulse with read data or an error flag. It occupies the Data_Memory slot of the single-cycle CPU and is the first data-path block that requires a request/ready handshake. Storage is word-organised, byte-addressed, with 32-bit aligned accesses only.

## Interface
Parameters:
- `DEPTH_WORDS`, 128: number of 32-bit words; power of two, 2..1024.
- `LATENCY`, 2: wait cycles between acceptance and access, 0..15.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  request valid; sampled only in IDLE.
- `MemRead_i`  in  1  request is a load.
- `MemWrite_i`  in  1  request is a store.
- `addr_i`  in  32  byte address.
- `data_i`  in  32  store data.
- `ready_o`  out  1  completion pulse, exactly one cycle per accepted request.
- `data_o`  out  32  load data; valid while `ready_o`=1, held until the next successful load.
- `err_o`  out  1  completion status, valid with `ready_o`; held until the next completion.
- `busy_o`  out  1  request in flight (WAIT or RESP).

## Operation
- States: IDLE, WAIT, RESP. Down-counter `cnt` is 4 bits.
- IDLE: at an edge with `req_i`=1, latch `addr_i`, `data_i`, `MemRead_i`, `MemWrite_i`, set `cnt`<=`LATENCY`, go to WAIT. With `req_i`=0, stay.
- WAIT: if `cnt`==0, perform the access and go to RESP; else `cnt`<=`cnt`-1. Inputs are ignored.
- RESP: `ready_o`=1 for this cycle; unconditionally return to IDLE. A `req_i` held during RESP is not accepted until the following IDLE edge.
- Access decode on the latched request:
  - error if `addr[1:0]`!=0,
  - error if word index `addr[31:2]` >= `DEPTH_WORDS`,
  - error if `MemRead`==`MemWrite`, i.e. both set or neither set.
- On error: no write, `data_o` unchanged, `err_o`<=1.
- Legal store: `mem[addr[31:2]]`<=`data`, `err_o`<=0, `data_o` unchanged.
- Legal load: `data_o`<=`mem[addr[31:2]]`, `err_o`<=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- Reset (`rst_i`=0, asynchronous): state IDLE, `cnt`=0, `ready_o`=0, `busy_o`=0, `err_o`=0, `data_o`=0, all memory words=0. Takes effect immediately and holds while low.
- Reset mid-request: the request is aborted. No write occurs and no `ready_o` pulse is produced.
- Accept edge t0, then:
  - access performed at edge t0+`LATENCY`+1,
  - `ready_o` high from edge t0+`LATENCY`+1 to edge t0+`LATENCY`+2,
  - state is IDLE again after edge t0+`LATENCY`+2.
- `busy_o` is high from edge t0+1 to edge t0+`LATENCY`+2.
- Earliest next accept is edge t0+`LATENCY`+3. Peak throughput is one request per `LATENCY`+3 cycles.
- `LATENCY`=0: `ready_o` is high during the cycle immediately after the accept cycle.
- A store followed by a load to the same word: the load returns the stored value, because the store completes before the load can be accepted.
- `ready_o` never asserts on two consecutive cycles.

## Test plan
- Reset: drive `rst_i`=0 mid-cycle -> all outputs 0 immediately. After release, a load from 0x0 returns `data_o`=0x00000000 with `err_o`=0.
- `LATENCY`=2: store 0xDEADBEEF to 0x10 accepted at t0, then load 0x10 -> each `ready_o` pulses exactly at t0+3 relative to its own accept edge. The load gives `data_o`=0xDEADBEEF, `err_o`=0, and `busy_o` is high for exactly 3 cycles per request.
- Error cases, each completing with `err_o`=1, no memory change and `data_o` unchanged:
  - store to 0x12 (misaligned),
  - store to 0x200 with `DEPTH_WORDS`=128 (out of range),
  - request with `MemRead_i`=`MemWrite_i`=1,
  - request with `MemRead_i`=`MemWrite_i`=0.
- Busy hold: keep `req_i`=1 with changing addr/data during WAIT and RESP -> only the first request is serviced. The second is accepted at t0+5 (`LATENCY`=2) using the inputs present at that edge.
- Reset mid-op: store 0x12345678 to 0x20 is accepted, then `rst_i`=0 pulses during WAIT -> no `ready_o` pulse, and a later load of 0x20 returns 0x00000000.
- `LATENCY`=0 sweep: store then load 16 sequential words 0x0..0x3C with pattern addr*3 -> every read matches, and `ready_o` appears one cycle after each accept.
